mips_bus_mem_responder: RTL and testbench

//   Synthesizable memory slave (responder) for the mips_cpu_bus Avalon-style bus: services CPU reads/writes and drives waitrequest.

---
 rtl/mips_bus_pkg.sv | 20 ++
 rtl/mips_bus_wait_lfsr.sv | 28 ++
 rtl/mips_bus_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_mips_bus_mem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus memory responder.
// Used by mips_bus_mem_responder and mips_bus_wait_lfsr.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    localparam int          BUS_DATA_W = 32;
    localparam int          BUS_BE_W   = 4;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    // Galois step for x^16 + x^14 + x^13 + x^11 + 1
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

endpackage

// File: rtl/mips_bus_wait_lfsr.sv
// Free-running 16-bit Galois LFSR that picks per-transfer wait counts.
// Only instantiated when MIPS_BUS_RANDOM_WAIT_EN is defined.
module mips_bus_wait_lfsr
    import mips_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mips_bus_mem_responder.sv
// Avalon-style memory responder with programmable wait states for mips_cpu_bus.
// Define MIPS_BUS_RANDOM_WAIT_EN for LFSR-driven random wait counts.
module mips_bus_mem_responder
    import mips_bus_pkg::*;
#(
    parameter string       RAM_FILE    = "",
    parameter logic [31:0] ADDR_BASE   = 32'hBFC00000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter int          MAX_WAIT    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [BUS_BE_W-1:0]   byteenable,
    input  logic [BUS_DATA_W-1:0] writedata,
    output logic                  waitrequest,
    output logic [BUS_DATA_W-1:0] readdata,
    output logic                  err,
    output logic [31:0]           txn_count
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);

    if (ADDR_BASE[1:0] != 2'b00) begin : g_bad_base
        $error("ADDR_BASE must be word aligned");
    end
    if ((1 << IDX_W) != DEPTH_WORDS) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of 2");
    end
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be 1..15");
    end
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max
        $error("MAX_WAIT must be 1..15");
    end

    resp_state_t           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BUS_BE_W-1:0]   be_q, be_d;
    logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic                  hit_q, hit_d;
    logic                  err_q, err_d;
    logic [31:0]           txn_q, txn_d;

    logic [BUS_DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [BUS_DATA_W-1:0] mem_rd_q;

    logic                  req;
    logic [31:0]           offset;
    logic                  in_win;
    logic                  bad_req;
    logic [IDX_W-1:0]      rd_idx;
    logic [3:0]            wait_load;
    logic                  commit;

`ifdef MIPS_BUS_RANDOM_WAIT_EN
    logic [15:0] lfsr;

    mips_bus_wait_lfsr u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (lfsr)
    );

    assign wait_load = 4'(lfsr % 16'(MAX_WAIT));
`else
    assign wait_load = 4'(WAIT_CYCLES - 1);
`endif

    assign req     = read | write;
    assign offset  = address - ADDR_BASE;
    assign in_win  = (address >= ADDR_BASE) && (offset < WIN_BYTES);
    assign bad_req = (read & write) | (address[1:0] != 2'b00) | ~in_win;

    // The RAM read port follows the live address in IDLE so that a
    // zero-wait transfer has its data ready on entry to RESP.
    assign rd_idx = (state_q == IDLE) ? offset[IDX_W+1:2] : idx_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        hit_d       = hit_q;
        err_d       = err_q;
        txn_d       = txn_q;
        waitrequest = 1'b0;
        commit      = 1'b0;
        unique case (state_q)
            IDLE: begin
                waitrequest = req & reset;
                if (req) begin
                    idx_d   = offset[IDX_W+1:2];
                    be_d    = byteenable;
                    wdata_d = writedata;
                    is_wr_d = write & ~read;
                    hit_d   = in_win;
                    cnt_d   = wait_load;
                    if (bad_req) begin
                        err_d = 1'b1;
                    end
                    state_d = (wait_load == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                waitrequest = 1'b1;
                cnt_d       = cnt_q - 4'd1;
                if (!req) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                commit  = is_wr_q & hit_q;
                txn_d   = txn_q + 32'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && reset) begin
            for (int b = 0; b < BUS_BE_W; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
        mem_rd_q <= mem_q[rd_idx];
    end

    assign readdata  = (state_q == RESP && hit_q && !is_wr_q) ? mem_rd_q : '0;
    assign err       = err_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// Directed bench for mips_bus_mem_responder: two instances (W=1, W=3).
// Build with MIPS_BUS_RANDOM_WAIT_EN to run the random-wait read sweep.
module tb_mips_bus_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr  [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [3:0]  be    [2];
    logic [31:0] wd    [2];
    logic        wq    [2];
    logic [31:0] rdata [2];
    logic        errf  [2];
    logic [31:0] cnt   [2];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    mips_bus_mem_responder #(.WAIT_CYCLES(1)) u_w1 (
        .clk         (clk),
        .reset       (rst_n),
        .address     (addr[0]),
        .read        (rd[0]),
        .write       (wr[0]),
        .byteenable  (be[0]),
        .writedata   (wd[0]),
        .waitrequest (wq[0]),
        .readdata    (rdata[0]),
        .err         (errf[0]),
        .txn_count   (cnt[0])
    );

    mips_bus_mem_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clk         (clk),
        .reset       (rst_n),
        .address     (addr[1]),
        .read        (rd[1]),
        .write       (wr[1]),
        .byteenable  (be[1]),
        .writedata   (wd[1]),
        .waitrequest (wq[1]),
        .readdata    (rdata[1]),
        .err         (errf[1]),
        .txn_count   (cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int d, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] data,
                        input logic [3:0] b, output int stalls,
                        output logic [31:0] got);
        @(posedge clk); #1;
        addr[d] = a;
        rd[d]   = r;
        wr[d]   = w;
        wd[d]   = data;
        be[d]   = b;
        #1;
        stalls = 0;
        while (wq[d] === 1'b1 && stalls < 40) begin
            @(posedge clk); #1;
            stalls++;
        end
        got = rdata[d];
        @(posedge clk); #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    task automatic wr_do(input int d, input logic [31:0] a,
                         input logic [31:0] data, input logic [3:0] b,
                         input int exp_st, input string tag);
        int          st;
        logic [31:0] got;
        xfer(d, 1'b0, 1'b1, a, data, b, st, got);
        chk({tag, "_stall"}, st, exp_st);
    endtask

    task automatic rd_chk(input int d, input logic [31:0] a,
                          input logic [31:0] exp, input int exp_st,
                          input string tag);
        int          st;
        logic [31:0] got;
        exp_q.push_back(exp);
        xfer(d, 1'b1, 1'b0, a, 32'h0, 4'h0, st, got);
        chk({tag, "_stall"}, st, exp_st);
        chk(tag, got, exp_q.pop_front());
    endtask

    initial begin
        int          st;
        logic [31:0] got;
        for (int i = 0; i < 2; i++) begin
            addr[i] = 32'hBFC00000;
            rd[i]   = 1'b0;
            wr[i]   = 1'b0;
            be[i]   = 4'h0;
            wd[i]   = 32'h0;
        end
        rst_n = 1'b0;
        rd[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wq", wq[0], 0);
        chk("rst_rdata", rdata[0], 0);
        chk("rst_err", errf[0], 0);
        chk("rst_cnt", cnt[1], 0);
        rd[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MIPS_BUS_RANDOM_WAIT_EN
        begin
            logic [31:0] img [16];
            bit          seen [1:4];
            for (int k = 1; k <= 4; k++) seen[k] = 1'b0;
            for (int k = 0; k < 16; k++) begin
                img[k] = $urandom;
                xfer(1, 1'b0, 1'b1, 32'hBFC00000 + 32'(4 * k), img[k],
                     4'hF, st, got);
                chk("rnd_w_stall_ok", 32'(st >= 1 && st <= 4), 1);
            end
            for (int n = 0; n < 200; n++) begin
                int k;
                k = $urandom_range(15, 0);
                exp_q.push_back(img[k]);
                xfer(1, 1'b1, 1'b0, 32'hBFC00000 + 32'(4 * k), 32'h0,
                     4'h0, st, got);
                chk("rnd_stall_ok", 32'(st >= 1 && st <= 4), 1);
                if (st >= 1 && st <= 4) seen[st] = 1'b1;
                chk("rnd_data", got, exp_q.pop_front());
            end
            for (int k = 1; k <= 4; k++) begin
                chk("rnd_seen", 32'(seen[k]), 1);
            end
            chk("rnd_err", errf[1], 0);
        end
`else
        wr_do(0, 32'hBFC00000, 32'h2402000A, 4'hF, 1, "t1_w");
        rd_chk(0, 32'hBFC00000, 32'h2402000A, 1, "t1_r");
        chk("t1_rd_clr", rdata[0], 0);
        chk("t1_cnt", cnt[0], 2);
        chk("t1_err", errf[0], 0);

        wr_do(1, 32'hBFC00004, 32'h11223344, 4'hF, 3, "t2_init");
        wr_do(1, 32'hBFC00004, 32'hDEADBEEF, 4'b0101, 3, "t2_w");
        rd_chk(1, 32'hBFC00004, 32'h11AD33EF, 3, "t2_r");
        chk("t2_rd_clr", rdata[1], 0);
        wr_do(1, 32'hBFC00004, 32'hFFFFFFFF, 4'h0, 3, "be0_w");
        rd_chk(1, 32'hBFC00004, 32'h11AD33EF, 3, "be0_r");
        chk("be0_cnt", cnt[1], 5);

        wr_do(1, 32'hBFC00FFC, 32'hCAFEF00D, 4'hF, 3, "top_w");
        rd_chk(1, 32'hBFC00FFC, 32'hCAFEF00D, 3, "top_r");
        chk("top_err", errf[1], 0);

        wr_do(1, 32'hBFC00008, 32'h0BADF00D, 4'hF, 3, "drop_pre");
        @(posedge clk); #1;
        addr[1] = 32'hBFC00008;
        wd[1]   = 32'h12345678;
        be[1]   = 4'hF;
        wr[1]   = 1'b1;
        @(posedge clk); #1;
        chk("drop_wq_wait", wq[1], 1);
        wr[1] = 1'b0;
        @(posedge clk); #1;
        chk("drop_err", errf[1], 1);
        chk("drop_cnt", cnt[1], 8);
        chk("drop_wq_idle", wq[1], 0);
        rd_chk(1, 32'hBFC00008, 32'h0BADF00D, 3, "drop_r");

        wr_do(1, 32'h00000010, 32'h55555555, 4'hF, 3, "oor_w");
        chk("oor_cnt", cnt[1], 10);
        rd_chk(1, 32'h00000010, 32'h0, 3, "oor_r");
        rd_chk(1, 32'hBFC01000, 32'h0, 3, "oor_edge_r");
        rd_chk(1, 32'hBFC00004, 32'h11AD33EF, 3, "oor_keep");
        chk("oor_err", errf[1], 1);

        chk("rw_err_pre", errf[0], 0);
        exp_q.push_back(32'h2402000A);
        xfer(0, 1'b1, 1'b1, 32'hBFC00000, 32'hFFFFFFFF, 4'hF, st, got);
        chk("rw_stall", st, 1);
        chk("rw_data", got, exp_q.pop_front());
        chk("rw_err", errf[0], 1);
        rd_chk(0, 32'hBFC00000, 32'h2402000A, 1, "rw_keep");
        rd_chk(0, 32'hBFC00002, 32'h2402000A, 1, "misalign_r");
        chk("rw_sticky", errf[0], 1);
        chk("rw_cnt", cnt[0], 5);

        @(posedge clk); #1;
        addr[1] = 32'hBFC00004;
        wd[1]   = 32'h00000000;
        be[1]   = 4'hF;
        wr[1]   = 1'b1;
        @(posedge clk); #1;
        chk("ar_wq_wait", wq[1], 1);
        rst_n = 1'b0;
        #1;
        chk("ar_wq", wq[1], 0);
        chk("ar_cnt", cnt[1], 0);
        chk("ar_err", errf[1], 0);
        wr[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk(1, 32'hBFC00004, 32'h11AD33EF, 3, "ar_keep");
        chk("ar_cnt_after", cnt[1], 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
